// File: rtl/conv_window_if.sv
// Pixel-stream in / sliding-window out bundle for conv_window_gen.
// The master side feeds pixels; the slave side (the generator) returns windows.
interface conv_window_if #(
  parameter int WIDTH     = 28,
  parameter int HEIGHT    = 28,
  parameter int DATA_BITS = 8,
  parameter int K         = 5
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic                     clear;
  logic                     valid_in;
  logic [DATA_BITS-1:0]     data_in;
  logic [K*K*DATA_BITS-1:0] win_out;
  logic                     valid_out;
  logic [RW-1:0]            out_row;
  logic [CW-1:0]            out_col;
  logic                     frame_done;

  modport master (
    output clear, valid_in, data_in,
    input  win_out, valid_out, out_row, out_col, frame_done
  );

  modport slave (
    input  clear, valid_in, data_in,
    output win_out, valid_out, out_row, out_col, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Sliding K x K window generator over a raster pixel stream, using K-1 line
// buffers and a shifting window register, with optional stride-2 decimation.
module conv_window_gen #(
  parameter int WIDTH     = 28,
  parameter int HEIGHT    = 28,
  parameter int DATA_BITS = 8,
  parameter int K         = 5,
  parameter int STRIDE    = 1
) (
  input logic         clk,
  input logic         rst_n,
  conv_window_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int SH = STRIDE - 1;
  localparam int FW = K * K * DATA_BITS;
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);

  logic [CW-1:0]        col_r;
  logic [RW-1:0]        row_r;
  logic [DATA_BITS-1:0] line_r [K-1][WIDTH];
  logic [DATA_BITS-1:0] win_r [K][K];
  logic [DATA_BITS-1:0] column_s [K];
  logic [DATA_BITS-1:0] next_win_s [K][K];
  logic [FW-1:0]        flat_s;
  logic                 accept_s;
  logic                 emit_s;
  logic                 last_s;
  logic [CW-1:0]        col_off_s;
  logic [RW-1:0]        row_off_s;

  logic                 valid_out_r;
  logic                 frame_done_r;
  logic [FW-1:0]        win_out_r;
  logic [RW-1:0]        out_row_r;
  logic [CW-1:0]        out_col_r;

  // Accept/emit decision; column/row gating keeps previous rows and frames out
  always_comb begin
    accept_s  = bus.valid_in & ~bus.clear;
    col_off_s = col_r - COL_FIRST;
    row_off_s = row_r - ROW_FIRST;
    emit_s    = 1'b0;
    if (accept_s && (row_r >= ROW_FIRST) && (col_r >= COL_FIRST)) begin
      if (STRIDE == 1) begin
        emit_s = 1'b1;
      end else begin
        emit_s = ~row_off_s[0] & ~col_off_s[0];
      end
    end else begin
      emit_s = 1'b0;
    end
    last_s = accept_s && (row_r == ROW_LAST) && (col_r == COL_LAST);
  end

  // Incoming column (oldest row at index 0) and the window after this shift
  always_comb begin
    for (int i = 0; i < K; i++) begin
      column_s[i] = '0;
    end
    for (int i = 0; i < K - 1; i++) begin
      column_s[i] = line_r[i][col_r];
    end
    column_s[K-1] = bus.data_in;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        next_win_s[i][j] = win_r[i][j+1];
      end
      next_win_s[i][K-1] = column_s[i];
    end
    flat_s = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        flat_s[(i*K+j)*DATA_BITS +: DATA_BITS] = next_win_s[i][j];
      end
    end
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= '0;
      row_r <= '0;
    end else if (bus.clear) begin
      col_r <= '0;
      row_r <= '0;
    end else if (accept_s) begin
      if (col_r == COL_LAST) begin
        col_r <= '0;
        row_r <= (row_r == ROW_LAST) ? '0 : row_r + 1'b1;
      end else begin
        col_r <= col_r + 1'b1;
      end
    end
  end

  // Line buffers age by one row per column visit; window shifts left per pixel
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int i = 0; i < K - 2; i++) begin
        line_r[i][col_r] <= line_r[i+1][col_r];
      end
      line_r[K-2][col_r] <= bus.data_in;
      win_r <= next_win_s;
    end
  end

  // Registered outputs; window and coordinates hold between valid cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out_r  <= 1'b0;
      frame_done_r <= 1'b0;
      win_out_r    <= '0;
      out_row_r    <= '0;
      out_col_r    <= '0;
    end else begin
      valid_out_r  <= emit_s;
      frame_done_r <= last_s;
      if (emit_s) begin
        win_out_r <= flat_s;
        out_row_r <= row_off_s >> SH;
        out_col_r <= col_off_s >> SH;
      end
    end
  end

  assign bus.valid_out  = valid_out_r;
  assign bus.frame_done = frame_done_r;
  assign bus.win_out    = win_out_r;
  assign bus.out_row    = out_row_r;
  assign bus.out_col    = out_col_r;
endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench: a 5x5/stride-1 and a 3x3/stride-2 generator share one
// pixel stream; the driver queues expected windows, a negedge monitor checks.
module tb_conv_window_gen;
  localparam int W = 28, H = 28, DB = 8;
  localparam int K1 = 5, S1 = 1, K2 = 3, S2 = 2;
  localparam int MAXW = K1 * K1 * DB;

  typedef struct {
    logic [MAXW-1:0] win;
    int              orow;
    int              ocol;
    longint          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic vin = 1'b0;
  logic [DB-1:0] din = 8'd0;

  always #5 clk = ~clk;

  conv_window_if #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .K(K1)) b1 ();
  conv_window_if #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .K(K2)) b2 ();

  assign b1.clear = clr;
  assign b1.valid_in = vin;
  assign b1.data_in = din;
  assign b2.clear = clr;
  assign b2.valid_in = vin;
  assign b2.data_in = din;

  conv_window_gen #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .K(K1), .STRIDE(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  conv_window_gen #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .K(K2), .STRIDE(S2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));

  exp_t   q [2][$];
  longint fq [2][$];
  int     cnt [2];
  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;
  logic [DB-1:0] img [H][W];
  int     pr = 0;
  int     pc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [MAXW-1:0] act, input logic [MAXW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Window expected for a kxk/stride-s generator after accepting pixel (r,c)
  function automatic bit build(input int k, input int s, input int r, input int c, output exp_t e);
    e.win = '0;
    e.orow = 0;
    e.ocol = 0;
    e.cyc = cyc + 1;
    if (r < k - 1 || c < k - 1 || (r - k + 1) % s != 0 || (c - k + 1) % s != 0) return 1'b0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        e.win[(i*k+j)*DB +: DB] = img[r-k+1+i][c-k+1+j];
    e.orow = (r - k + 1) / s;
    e.ocol = (c - k + 1) / s;
    return 1'b1;
  endfunction

  task automatic step(input logic v, input logic [DB-1:0] d, input logic cl);
    exp_t e;
    @(posedge clk);
    #1;
    vin = v;
    din = d;
    clr = cl;
    if (cl) begin
      pr = 0;
      pc = 0;
    end else if (v) begin
      img[pr][pc] = d;
      if (build(K1, S1, pr, pc, e)) q[0].push_back(e);
      if (build(K2, S2, pr, pc, e)) q[1].push_back(e);
      if (pr == H - 1 && pc == W - 1) begin
        fq[0].push_back(cyc + 1);
        fq[1].push_back(cyc + 1);
      end
      if (pc == W - 1) begin
        pc = 0;
        pr = (pr == H - 1) ? 0 : pr + 1;
      end else begin
        pc = pc + 1;
      end
    end
  endtask

  task automatic run_pixels(input int base, input int first, input int last, input bit gaps);
    for (int idx = first; idx <= last; idx++) begin
      if (gaps && $urandom_range(0, 1) == 1) step(1'b0, 8'd0, 1'b0);
      step(1'b1, 8'((idx + base) % 256), 1'b0);
    end
  endtask

  task automatic mon(input int id, input logic vo, input logic fd, input logic [MAXW-1:0] w,
                     input int orow, input int ocol);
    exp_t e;
    longint t;
    if (vo) begin
      cnt[id]++;
      if (q[id].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid%0d: actual=1 required=0 at cycle %0d", id, cyc);
      end else begin
        e = q[id].pop_front();
        check($sformatf("win%0d", id), w, e.win);
        check($sformatf("out_row%0d", id), MAXW'(orow), MAXW'(e.orow));
        check($sformatf("out_col%0d", id), MAXW'(ocol), MAXW'(e.ocol));
        check($sformatf("valid_cycle%0d", id), MAXW'(cyc), MAXW'(e.cyc));
      end
    end else if (q[id].size() > 0 && q[id][0].cyc <= cyc) begin
      e = q[id].pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_valid%0d: actual=0 required=1 at cycle %0d", id, e.cyc);
    end
    if (fd) begin
      if (fq[id].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_frame_done%0d: actual=1 required=0 at cycle %0d", id, cyc);
      end else begin
        t = fq[id].pop_front();
        check($sformatf("frame_done_cycle%0d", id), MAXW'(cyc), MAXW'(t));
      end
    end else if (fq[id].size() > 0 && fq[id][0] <= cyc) begin
      t = fq[id].pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_frame_done%0d: actual=0 required=1 at cycle %0d", id, t);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, b1.valid_out, b1.frame_done, MAXW'(b1.win_out), int'(b1.out_row), int'(b1.out_col));
      mon(1, b2.valid_out, b2.frame_done, MAXW'(b2.win_out), int'(b2.out_row), int'(b2.out_col));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_out"}, MAXW'(b1.valid_out), '0);
    check({tag, "_frame_done"}, MAXW'(b1.frame_done), '0);
    check({tag, "_win_out"}, MAXW'(b1.win_out), '0);
    check({tag, "_out_row"}, MAXW'(b1.out_row), '0);
    check({tag, "_out_col"}, MAXW'(b1.out_col), '0);
    check({tag, "_valid_out2"}, MAXW'(b2.valid_out), '0);
  endtask

  task automatic check_counts(input string tag, input int c0, input int c1, input int n);
    check({tag, "_count1"}, MAXW'(cnt[0] - c0), MAXW'(576 * n));
    check({tag, "_count2"}, MAXW'(cnt[1] - c1), MAXW'(169 * n));
  endtask

  initial begin
    int c0, c1;
    cnt[0] = 0;
    cnt[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Continuous frame: both generators, then the held last windows
    c0 = cnt[0]; c1 = cnt[1];
    run_pixels(0, 0, W * H - 1, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b0);
    check_counts("frame", c0, c1, 1);
    check("hold_elem0", MAXW'(b1.win_out[7:0]), MAXW'(8'd155));
    check("hold_elem24", MAXW'(b1.win_out[199:192]), MAXW'(8'd15));
    check("hold_row1", MAXW'(b1.out_row), MAXW'(23));
    check("hold_col1", MAXW'(b1.out_col), MAXW'(23));
    check("hold_row2", MAXW'(b2.out_row), MAXW'(12));
    check("hold_col2", MAXW'(b2.out_col), MAXW'(12));

    // Gapped input stream
    c0 = cnt[0]; c1 = cnt[1];
    run_pixels(0, 0, W * H - 1, 1'b1);
    repeat (3) step(1'b0, 8'd0, 1'b0);
    check_counts("gapped", c0, c1, 1);

    // Two frames back-to-back, second offset by 100
    c0 = cnt[0]; c1 = cnt[1];
    run_pixels(0, 0, W * H - 1, 1'b0);
    run_pixels(100, 0, W * H - 1, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b0);
    check_counts("b2b", c0, c1, 2);

    // Asynchronous reset mid-frame, then a full frame
    run_pixels(0, 0, 300, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q[0].delete(); q[1].delete(); fq[0].delete(); fq[1].delete();
    pr = 0;
    pc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    c0 = cnt[0]; c1 = cnt[1];
    run_pixels(0, 0, W * H - 1, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b0);
    check_counts("after_reset", c0, c1, 1);

    // Clear together with a valid pixel at index 200; next pixel is (0,0)
    run_pixels(0, 0, 199, 1'b0);
    step(1'b1, 8'd200, 1'b1);
    step(1'b0, 8'd0, 1'b0);
    check("clear_valid_out", MAXW'(b1.valid_out), '0);
    c0 = cnt[0]; c1 = cnt[1];
    run_pixels(0, 0, W * H - 1, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b0);
    check_counts("after_clear", c0, c1, 1);

    check("pending_windows1", MAXW'(q[0].size()), '0);
    check("pending_windows2", MAXW'(q[1].size()), '0);
    check("pending_frame_done", MAXW'(fq[0].size() + fq[1].size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 28: frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 28: frame height in pixels.
REQ-003 SHALL have parameter DATA_BITS, default 8: pixel width.
REQ-004 SHALL have parameter K, default 5: square window size, legal range 2..7, K<=WIDTH, K<=HEIGHT.
REQ-005 SHALL have parameter STRIDE, default 1: window step, legal values 1 and 2, applied in both axes.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-009 SHALL have port valid_in, input, 1 bit: data_in is valid this cycle.
REQ-010 SHALL have port data_in, input, DATA_BITS: pixel, raster order, row-major.
REQ-011 SHALL have port win_out, output, K*K*DATA_BITS: flattened window.
REQ-012 SHALL have port valid_out, output, 1 bit: win_out valid this cycle.
REQ-013 SHALL have port out_row and out_col, outputs, $clog2(HEIGHT) and $clog2(WIDTH) bits: output-grid coordinates of the window on win_out.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-015 SHALL accept a pixel only in cycles with valid_in=1; with valid_in=0, counters, line buffers and window SHALL hold, and valid_out SHALL be 0 in the following cycle.
REQ-016 SHALL track the input column c (0..WIDTH-1) and row r (0..HEIGHT-1) of each accepted pixel: c wraps to 0 with r+1; after (HEIGHT-1, WIDTH-1), both wrap to 0.
REQ-017 SHALL store K-1 previous rows in line buffers of depth WIDTH, plus a K x K window register shifted left by one column per accepted pixel.
REQ-018 SHALL assert valid_out exactly one cycle after accepting pixel (r,c) iff r>=K-1, c>=K-1, (r-K+1)%STRIDE==0 and (c-K+1)%STRIDE==0.
REQ-019 When valid_out=1, win_out[(i*K+j)*DATA_BITS +: DATA_BITS] SHALL equal pixel (r-K+1+i, c-K+1+j), for i,j in 0..K-1.
REQ-020 When valid_out=1, out_row SHALL equal (r-K+1)/STRIDE and out_col SHALL equal (c-K+1)/STRIDE.
REQ-021 Window columns SHALL never mix pixels from different rows: no valid_out while c<K-1 after a row wrap.
REQ-022 Output count per frame SHALL be ((HEIGHT-K)/STRIDE+1)*((WIDTH-K)/STRIDE+1), integer division.
REQ-023 frame_done SHALL pulse for one cycle, one cycle after accepting pixel (HEIGHT-1, WIDTH-1), coincident with the last valid_out when it exists.
REQ-024 Back-to-back frames SHALL need no idle cycles; pixel (0,0) of the next frame MAY arrive the cycle after the last pixel.
REQ-025 Line-buffer contents from a previous frame SHALL never appear in a valid window, which follows from REQ-018 gating.
REQ-026 clear=1 SHALL zero the counters, valid_out and frame_done at the next edge, discarding any pixel presented that cycle; clear SHALL take priority over valid_in.
REQ-027 win_out, out_row and out_col SHALL hold their last value while valid_out=0.

Reset
REQ-028 rst_n=0 SHALL immediately and asynchronously force valid_out=0, frame_done=0, win_out=0, out_row=0, out_col=0, r=0 and c=0.
REQ-029 Line-buffer RAM contents need not be reset.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first pixel accepted after deassertion SHALL be (0,0).

Verification
REQ-031 Defaults, data_in=index mod 256, valid_in=1 continuously -> first valid_out the cycle after pixel 116; win_out element 0 = 0, element 24 = 116; 576 valid_out, then frame_done.
REQ-032 STRIDE=2, K=3, 28x28 frame -> 169 windows; first window at (2,2) with out_row=0 and out_col=0; last window has out_row=12 and out_col=12.
REQ-033 Defaults with valid_in randomly 50% low -> windows and count identical to REQ-031; no valid_out in any cycle following valid_in=0.
REQ-034 Two frames back-to-back (frame 2 = frame 1 + 100) -> frame 2 windows contain only frame-2 pixels; frame_done pulses twice.
REQ-035 rst_n pulsed low after pixel 300, then a full frame -> all outputs 0 during reset; new frame behaves exactly as REQ-031.
REQ-036 clear asserted together with valid_in at pixel 200 -> that pixel dropped; the next pixel is treated as (0,0); no frame_done for the aborted frame.
